tt_byte_port_host: RTL



---
 rtl/tt_port_pkg.sv | 33 +++
 rtl/tt_byte_port_host.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tt_port_pkg.sv
// rtl/tt_port_pkg.sv - shared sizing, state encoding and byte helper for the TT byte-port host
package tt_port_pkg;

   localparam int unsigned DEF_LOG2_BYTES_IN  = 3;
   localparam int unsigned DEF_LOG2_BYTES_OUT = 2;
   localparam int unsigned DEF_SETTLE_CYCLES  = 2;

   localparam int unsigned READ_SEL_LSB  = 4;
   localparam int unsigned MAX_BYTES     = 32;
   localparam int unsigned MAX_WORD_BITS = MAX_BYTES * 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_READ_SET = 3'd3,
      ST_READ_CAP = 3'd4,
      ST_RESP     = 3'd5
   } port_state_e;

   function automatic int unsigned num_bytes(input int unsigned log2_bytes);
      return 32'd1 << log2_bytes;
   endfunction

   // Callers zero-extend their word to MAX_WORD_BITS so one helper serves any width.
   function automatic logic [7:0] pick_byte(input logic [MAX_WORD_BITS-1:0] word,
                                            input logic [4:0]               idx);
      logic [7:0] base;
      base = {idx, 3'b000};
      return word[base +: 8];
   endfunction

endpackage

// File: rtl/tt_byte_port_host.sv
// rtl/tt_byte_port_host.sv - serializes an operand word into the TT core and reads the result back
module tt_byte_port_host
   import tt_port_pkg::*;
#(
   parameter int unsigned LOG2_BYTES_IN  = DEF_LOG2_BYTES_IN,
   parameter int unsigned LOG2_BYTES_OUT = DEF_LOG2_BYTES_OUT,
   parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    req_valid,
   output logic                                    req_ready,
   input  logic [num_bytes(LOG2_BYTES_IN)*8-1:0]   req_data,
   output logic                                    rsp_valid,
   input  logic                                    rsp_ready,
   output logic [num_bytes(LOG2_BYTES_OUT)*8-1:0]  rsp_data,
   output logic [7:0]                              dut_data,
   output logic [7:0]                              dut_sel,
   input  logic [7:0]                              dut_rd
);

   localparam int unsigned BYTES_IN  = num_bytes(LOG2_BYTES_IN);
   localparam int unsigned BYTES_OUT = num_bytes(LOG2_BYTES_OUT);
   localparam int unsigned IN_W      = BYTES_IN * 8;
   localparam int unsigned OUT_W     = BYTES_OUT * 8;
   localparam int unsigned SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [LOG2_BYTES_IN-1:0]  WR_LAST     = LOG2_BYTES_IN'(BYTES_IN - 1);
   localparam logic [LOG2_BYTES_OUT-1:0] RD_LAST     = LOG2_BYTES_OUT'(BYTES_OUT - 1);
   localparam logic [SW-1:0]             SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   port_state_e                state_q, state_d;
   logic [IN_W-1:0]            op_q, op_d;
   logic [LOG2_BYTES_IN-1:0]   wr_idx_q, wr_idx_d;
   logic [LOG2_BYTES_OUT-1:0]  rd_idx_q, rd_idx_d;
   logic [LOG2_BYTES_OUT-1:0]  rd_sel_q, rd_sel_d;
   logic [SW-1:0]              settle_q, settle_d;
   logic [7:0]                 dut_data_q, dut_data_d;
   logic                       req_ready_q, req_ready_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [OUT_W-1:0]           rsp_data_q, rsp_data_d;

   logic [MAX_WORD_BITS-1:0]   op_ext;
   logic [MAX_WORD_BITS-1:0]   req_ext;

   assign op_ext  = MAX_WORD_BITS'(op_q);
   assign req_ext = MAX_WORD_BITS'(req_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         rd_sel_q    <= '0;
         settle_q    <= '0;
         dut_data_q  <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         rd_sel_q    <= rd_sel_d;
         settle_q    <= settle_d;
         dut_data_q  <= dut_data_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // The core writes on every edge, so the write field and data only ever move together.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      rd_sel_d    = rd_sel_q;
      settle_d    = settle_q;
      dut_data_d  = dut_data_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               op_d        = req_data;
               wr_idx_d    = '0;
               dut_data_d  = pick_byte(req_ext, 5'd0);
               req_ready_d = 1'b0;
               state_d     = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wr_idx_q == WR_LAST) begin
               settle_d = '0;
               state_d  = ST_SETTLE;
            end else begin
               wr_idx_d   = wr_idx_q + 1'b1;
               dut_data_d = pick_byte(op_ext, 5'(wr_idx_d));
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               rd_idx_d = '0;
               state_d  = ST_READ_SET;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_READ_SET: begin
            rd_sel_d = rd_idx_q;
            state_d  = ST_READ_CAP;
         end
         ST_READ_CAP: begin
            for (int j = 0; j < int'(BYTES_OUT); j++) begin
               if (rd_idx_q == LOG2_BYTES_OUT'(j)) begin
                  rsp_data_d[j*8 +: 8] = dut_rd;
               end
            end
            if (rd_idx_q == RD_LAST) begin
               state_d = ST_RESP;
            end else begin
               rd_idx_d = rd_idx_q + 1'b1;
               state_d  = ST_READ_SET;
            end
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      dut_sel = '0;
      dut_sel[LOG2_BYTES_IN-1:0]               = wr_idx_q;
      dut_sel[READ_SEL_LSB +: LOG2_BYTES_OUT]  = rd_sel_q;
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign dut_data  = dut_data_q;

endmodule
